// File: rtl/itlb_4kb_sfence_walker.sv
// -----------------------------------------------------------------------------
// itlb_4kb_sfence_walker
//
// Sequential SFENCE.VMA invalidation engine for the ITLB 4KB page array.
// One flush request is accepted in IDLE. The engine then reads ITLB sets
// through a 1-cycle-latency read port. For every valid way, it rebuilds the
// full VPN from the stored tag and the set index by undoing the index hash
// (index = VPN[W-1:0] ^ VPN[2W-1:W]). It then issues a per-set way-mask
// invalidate. While the walker is busy, the fill path must stall.
//
// Optional feature macro: ITLB_SFENCE_FULL_SWEEP_EN
//   defined   : VPN-specific flushes also sweep every set.
//   undefined : VPN-specific flushes read only the hashed set.
//
// Ports
//   CLK, nRST                  clock, async active-low reset
//   sfence_valid/ready         request handshake (ready only in IDLE)
//   sfence_VPN_specific        rs1 != x0, compare VPN
//   sfence_ASID_specific       rs2 != x0, compare ASID (non-global only)
//   sfence_VPN, sfence_ASID    request operands
//   array_read_valid/index     set read request (data returns next cycle)
//   array_read_*_by_way        returned valid/tag/ASID/G bits per way
//   array_inv_valid/index/
//   array_inv_way_mask         invalidate strobe, driven in CHECK only
//   busy                       high in READ, CHECK and DONE
//   done                       one-cycle completion pulse
// -----------------------------------------------------------------------------
module itlb_4kb_sfence_walker #(
  parameter int ASID_WIDTH               = 9,
  parameter int VPN_WIDTH                = 20,
  parameter int ITLB_4KBPAGE_INDEX_WIDTH = 4,
  parameter int ITLB_4KBPAGE_ASSOC       = 4
) (
  input  logic                                                    CLK,
  input  logic                                                    nRST,
  input  logic                                                    sfence_valid,
  output logic                                                    sfence_ready,
  input  logic                                                    sfence_VPN_specific,
  input  logic                                                    sfence_ASID_specific,
  input  logic [VPN_WIDTH-1:0]                                    sfence_VPN,
  input  logic [ASID_WIDTH-1:0]                                   sfence_ASID,
  output logic                                                    array_read_valid,
  output logic [ITLB_4KBPAGE_INDEX_WIDTH-1:0]                     array_read_index,
  input  logic [ITLB_4KBPAGE_ASSOC-1:0]                           array_read_valid_by_way,
  input  logic [ITLB_4KBPAGE_ASSOC*(VPN_WIDTH-ITLB_4KBPAGE_INDEX_WIDTH)-1:0] array_read_tag_by_way,
  input  logic [ITLB_4KBPAGE_ASSOC*ASID_WIDTH-1:0]                array_read_ASID_by_way,
  input  logic [ITLB_4KBPAGE_ASSOC-1:0]                           array_read_global_by_way,
  output logic                                                    array_inv_valid,
  output logic [ITLB_4KBPAGE_INDEX_WIDTH-1:0]                     array_inv_index,
  output logic [ITLB_4KBPAGE_ASSOC-1:0]                           array_inv_way_mask,
  output logic                                                    busy,
  output logic                                                    done
);

  localparam int IW        = ITLB_4KBPAGE_INDEX_WIDTH;
  localparam int NW        = ITLB_4KBPAGE_ASSOC;
  localparam int TAG_WIDTH = VPN_WIDTH - ITLB_4KBPAGE_INDEX_WIDTH;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_CHECK = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  state_t                  state_r;
  state_t                  state_s;
  logic [IW-1:0]           idx_r;
  logic                    vpn_spec_r;
  logic                    asid_spec_r;
  logic                    single_r;
  logic [VPN_WIDTH-1:0]    vpn_r;
  logic [ASID_WIDTH-1:0]   asid_r;
  logic                    single_s;
  logic                    last_set_s;
  logic [NW-1:0]           mask_s;

  // Set index a given VPN hashes to.
  function automatic logic [IW-1:0] hash_index(input logic [VPN_WIDTH-1:0] vpn);
    return vpn[IW-1:0] ^ vpn[2*IW-1:IW];
  endfunction

  // Per-way match mask for the set currently returned by the read port.
  // The stored tag holds VPN[VPN_WIDTH-1:W]. The low field is recovered as
  // idx ^ tag[W-1:0] because the index was formed by XORing those two fields.
  function automatic logic [NW-1:0] match_mask(
    input logic [IW-1:0]            idx,
    input logic                     vpn_spec,
    input logic                     asid_spec,
    input logic [VPN_WIDTH-1:0]     vpn,
    input logic [ASID_WIDTH-1:0]    asid,
    input logic [NW-1:0]            valid_by_way,
    input logic [NW*TAG_WIDTH-1:0]  tag_by_way,
    input logic [NW*ASID_WIDTH-1:0] asid_by_way,
    input logic [NW-1:0]            global_by_way
  );
    logic [NW-1:0]         m;
    logic [TAG_WIDTH-1:0]  tag;
    logic [VPN_WIDTH-1:0]  entry_vpn;
    logic [ASID_WIDTH-1:0] entry_asid;
    logic                  hit;
    m = {NW{1'b0}};
    for (int w = 0; w < NW; w++) begin
      tag        = tag_by_way[w*TAG_WIDTH +: TAG_WIDTH];
      entry_vpn  = {tag, idx ^ tag[IW-1:0]};
      entry_asid = asid_by_way[w*ASID_WIDTH +: ASID_WIDTH];
      hit        = valid_by_way[w];
      if (vpn_spec && (entry_vpn != vpn)) begin
        hit = 1'b0;
      end else begin
        hit = hit;
      end
      // Global mappings survive an ASID-specific fence.
      if (asid_spec && ((entry_asid != asid) || global_by_way[w])) begin
        hit = 1'b0;
      end else begin
        hit = hit;
      end
      m[w] = hit;
    end
    return m;
  endfunction

  // Single-set lookup decision for an incoming request.
  always_comb begin
`ifdef ITLB_SFENCE_FULL_SWEEP_EN
    single_s = 1'b0;
`else
    single_s = sfence_VPN_specific;
`endif
  end

  // Last-set detection and match mask for the current set.
  always_comb begin
    last_set_s = (idx_r == {IW{1'b1}});
    mask_s     = match_mask(idx_r, vpn_spec_r, asid_spec_r, vpn_r, asid_r,
                            array_read_valid_by_way, array_read_tag_by_way,
                            array_read_ASID_by_way, array_read_global_by_way);
  end

  // State register, request latch and sweep index.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_r     <= ST_IDLE;
      idx_r       <= {IW{1'b0}};
      vpn_spec_r  <= 1'b0;
      asid_spec_r <= 1'b0;
      single_r    <= 1'b0;
      vpn_r       <= {VPN_WIDTH{1'b0}};
      asid_r      <= {ASID_WIDTH{1'b0}};
    end else begin
      state_r <= state_s;
      case (state_r)
        ST_IDLE: begin
          if (sfence_valid) begin
            vpn_spec_r  <= sfence_VPN_specific;
            asid_spec_r <= sfence_ASID_specific;
            single_r    <= single_s;
            vpn_r       <= sfence_VPN;
            asid_r      <= sfence_ASID;
            idx_r       <= single_s ? hash_index(sfence_VPN) : {IW{1'b0}};
          end
        end
        ST_CHECK: begin
          // The index never wraps. The last set goes to DONE instead.
          if (!(single_r || last_set_s)) begin
            idx_r <= idx_r + {{(IW-1){1'b0}}, 1'b1};
          end
        end
        default: begin
        end
      endcase
    end
  end

  // Next-state logic.
  always_comb begin
    state_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (sfence_valid) begin
          state_s = ST_READ;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_READ: begin
        state_s = ST_CHECK;
      end
      ST_CHECK: begin
        if (single_r || last_set_s) begin
          state_s = ST_DONE;
        end else begin
          state_s = ST_READ;
        end
      end
      ST_DONE: begin
        state_s = ST_IDLE;
      end
      default: begin
        state_s = ST_IDLE;
      end
    endcase
  end

  // Outputs decoded from the state. Reset forces IDLE, so every output
  // except sfence_ready drops at once.
  always_comb begin
    sfence_ready       = 1'b0;
    busy               = 1'b0;
    done               = 1'b0;
    array_read_valid   = 1'b0;
    array_read_index   = {IW{1'b0}};
    array_inv_valid    = 1'b0;
    array_inv_index    = {IW{1'b0}};
    array_inv_way_mask = {NW{1'b0}};
    case (state_r)
      ST_IDLE: begin
        sfence_ready = 1'b1;
      end
      ST_READ: begin
        busy             = 1'b1;
        array_read_valid = 1'b1;
        array_read_index = idx_r;
      end
      ST_CHECK: begin
        busy               = 1'b1;
        array_inv_valid    = |mask_s;
        array_inv_index    = idx_r;
        array_inv_way_mask = mask_s;
      end
      ST_DONE: begin
        busy = 1'b1;
        done = 1'b1;
      end
      default: begin
        sfence_ready = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_itlb_4kb_sfence_walker.sv
// -----------------------------------------------------------------------------
// tb_itlb_4kb_sfence_walker
//
// Bench for itlb_4kb_sfence_walker. It holds the ITLB contents as plain
// arrays, one entry per set and way, and answers the read port one cycle
// after each request. For every flush, the expected invalidate list, read
// count and done cycle come from the fence rules applied to those arrays.
// Directed and $urandom-driven flushes are then compared against the DUT.
// -----------------------------------------------------------------------------
module tb_itlb_4kb_sfence_walker;

  localparam int AW   = 9;
  localparam int VW   = 20;
  localparam int IW   = 4;
  localparam int NW   = 4;
  localparam int TW   = VW - IW;
  localparam int NSET = 16;
`ifdef ITLB_SFENCE_FULL_SWEEP_EN
  localparam bit FULL_SWEEP = 1'b1;
`else
  localparam bit FULL_SWEEP = 1'b0;
`endif

  logic           CLK;
  logic           nRST;
  logic           sfence_valid;
  logic           sfence_ready;
  logic           sfence_VPN_specific;
  logic           sfence_ASID_specific;
  logic [VW-1:0]  sfence_VPN;
  logic [AW-1:0]  sfence_ASID;
  logic           array_read_valid;
  logic [IW-1:0]  array_read_index;
  logic [NW-1:0]  array_read_valid_by_way;
  logic [NW*TW-1:0] array_read_tag_by_way;
  logic [NW*AW-1:0] array_read_ASID_by_way;
  logic [NW-1:0]  array_read_global_by_way;
  logic           array_inv_valid;
  logic [IW-1:0]  array_inv_index;
  logic [NW-1:0]  array_inv_way_mask;
  logic           busy;
  logic           done;

  // ITLB contents model
  bit          mem_valid [NSET][NW];
  logic [15:0] mem_tag   [NSET][NW];
  logic [8:0]  mem_asid  [NSET][NW];
  bit          mem_g     [NSET][NW];

  int total = 0;
  int bad   = 0;

  int exp_q[$];
  int obs_q[$];
  int exp_reads;
  int exp_done;

  itlb_4kb_sfence_walker #(
    .ASID_WIDTH(AW), .VPN_WIDTH(VW),
    .ITLB_4KBPAGE_INDEX_WIDTH(IW), .ITLB_4KBPAGE_ASSOC(NW)
  ) dut (
    .CLK(CLK), .nRST(nRST),
    .sfence_valid(sfence_valid), .sfence_ready(sfence_ready),
    .sfence_VPN_specific(sfence_VPN_specific),
    .sfence_ASID_specific(sfence_ASID_specific),
    .sfence_VPN(sfence_VPN), .sfence_ASID(sfence_ASID),
    .array_read_valid(array_read_valid), .array_read_index(array_read_index),
    .array_read_valid_by_way(array_read_valid_by_way),
    .array_read_tag_by_way(array_read_tag_by_way),
    .array_read_ASID_by_way(array_read_ASID_by_way),
    .array_read_global_by_way(array_read_global_by_way),
    .array_inv_valid(array_inv_valid), .array_inv_index(array_inv_index),
    .array_inv_way_mask(array_inv_way_mask),
    .busy(busy), .done(done)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  // The array read port returns the requested set one cycle later.
  always @(posedge CLK) begin
    if (array_read_valid) begin
      for (int w = 0; w < NW; w++) begin
        array_read_valid_by_way[w]       <= mem_valid[array_read_index][w];
        array_read_tag_by_way[w*TW +: TW] <= mem_tag[array_read_index][w];
        array_read_ASID_by_way[w*AW +: AW] <= mem_asid[array_read_index][w];
        array_read_global_by_way[w]      <= mem_g[array_read_index][w];
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic clear_mem();
    for (int s = 0; s < NSET; s++)
      for (int w = 0; w < NW; w++) begin
        mem_valid[s][w] = 1'b0;
        mem_tag[s][w]   = 16'($urandom);
        mem_asid[s][w]  = 9'd6;
        mem_g[s][w]     = 1'b0;
      end
  endtask

  task automatic rand_mem(input int asid_max, input logic [15:0] hot_tag, input int hot_set);
    for (int s = 0; s < NSET; s++)
      for (int w = 0; w < NW; w++) begin
        mem_valid[s][w] = ($urandom_range(0, 3) != 0);
        mem_tag[s][w]   = ($urandom_range(0, 3) == 0 || (s == hot_set && $urandom_range(0, 1) == 1))
                          ? hot_tag : 16'($urandom);
        mem_asid[s][w]  = 9'($urandom_range(0, asid_max));
        mem_g[s][w]     = ($urandom_range(0, 3) == 0);
      end
  endtask

  // Expected behaviour from the fence rules.
  task automatic compute_expected(input bit vs, input bit as, input int vpn, input int asid);
    int first, last, m, full;
    bit single, ok;
    exp_q.delete();
    single = vs && !FULL_SWEEP;
    if (single) begin
      first = (vpn % 16) ^ ((vpn / 16) % 16);
      last  = first;
    end else begin
      first = 0;
      last  = NSET - 1;
    end
    for (int s = first; s <= last; s++) begin
      m = 0;
      for (int w = 0; w < NW; w++) begin
        ok = mem_valid[s][w];
        full = int'(mem_tag[s][w]) * 16 + (s ^ (int'(mem_tag[s][w]) % 16));
        if (vs && full != vpn) ok = 1'b0;
        if (as && (int'(mem_asid[s][w]) != asid || mem_g[s][w])) ok = 1'b0;
        if (ok) m = m + (1 << w);
      end
      if (m != 0) exp_q.push_back(s * 16 + m);
    end
    exp_reads = last - first + 1;
    exp_done  = 2 * exp_reads + 1;
  endtask

  task automatic run_flush(input string tag, input bit vs, input bit as,
                           input logic [19:0] vpn, input logic [8:0] asid);
    int reads, done_cyc, ndone, busy_cnt, n_cmp;
    logic ready_after;
    compute_expected(vs, as, int'(vpn), int'(asid));
    obs_q.delete();
    reads = 0; done_cyc = 0; ndone = 0; busy_cnt = 0; ready_after = 1'b0;
    @(negedge CLK);
    chk({tag, "_ready_idle"}, 32'(sfence_ready), 32'd1);
    sfence_valid         = 1'b1;
    sfence_VPN_specific  = vs;
    sfence_ASID_specific = as;
    sfence_VPN           = vpn;
    sfence_ASID          = asid;
    @(posedge CLK);
    #1 sfence_valid = 1'b0;
    for (int n = 1; n <= 36; n++) begin
      @(negedge CLK);
      if (array_read_valid) reads++;
      if (array_inv_valid) obs_q.push_back(int'(array_inv_index) * 16 + int'(array_inv_way_mask));
      if (done) begin
        ndone++;
        if (done_cyc == 0) done_cyc = n;
      end
      if (busy) busy_cnt++;
      if (n == exp_done + 1) ready_after = sfence_ready;
      // A request raised while the walker is busy must be ignored.
      if (n == 2) begin
        sfence_valid         = 1'b1;
        sfence_VPN_specific  = ~vs;
        sfence_ASID_specific = ~as;
        sfence_VPN           = ~vpn;
        sfence_ASID          = ~asid;
      end
      if (n == 3) sfence_valid = 1'b0;
    end
    chk({tag, "_done_cycle"}, 32'(done_cyc), 32'(exp_done));
    chk({tag, "_done_count"}, 32'(ndone), 32'd1);
    chk({tag, "_reads"}, 32'(reads), 32'(exp_reads));
    chk({tag, "_busy_cycles"}, 32'(busy_cnt), 32'(exp_done));
    chk({tag, "_ready_after"}, 32'(ready_after), 32'd1);
    chk({tag, "_inv_count"}, 32'(obs_q.size()), 32'(exp_q.size()));
    n_cmp = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
    for (int i = 0; i < n_cmp; i++)
      chk({tag, "_inv_idx_mask"}, 32'(obs_q[i]), 32'(exp_q[i]));
  endtask

  initial begin
    logic [19:0] rvpn;
    logic [8:0]  rasid;
    int          cnt;
    nRST = 1'b0;
    sfence_valid = 1'b0;
    sfence_VPN_specific = 1'b0;
    sfence_ASID_specific = 1'b0;
    sfence_VPN = 20'h0;
    sfence_ASID = 9'h0;
    array_read_valid_by_way = 4'h0;
    array_read_tag_by_way = 64'h0;
    array_read_ASID_by_way = 36'h0;
    array_read_global_by_way = 4'h0;
    clear_mem();
    #2;
    chk("rst_ready", 32'(sfence_ready), 32'd1);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_read_valid", 32'(array_read_valid), 32'd0);
    chk("rst_inv_valid", 32'(array_inv_valid), 32'd0);
    repeat (3) @(negedge CLK);
    nRST = 1'b1;

    // Flush all, every entry valid.
    rand_mem(3, 16'h1234, 1);
    for (int s = 0; s < NSET; s++) for (int w = 0; w < NW; w++) mem_valid[s][w] = 1'b1;
    run_flush("all", 1'b0, 1'b0, 20'h0, 9'h0);

    // ASID-only flush at set 2.
    clear_mem();
    mem_valid[2][0] = 1'b1; mem_asid[2][0] = 9'd5; mem_g[2][0] = 1'b0;
    mem_valid[2][1] = 1'b1; mem_asid[2][1] = 9'd5; mem_g[2][1] = 1'b1;
    mem_valid[2][2] = 1'b1; mem_asid[2][2] = 9'd6; mem_g[2][2] = 1'b0;
    mem_valid[9][3] = 1'b1; mem_asid[9][3] = 9'd6;
    run_flush("asid", 1'b0, 1'b1, 20'h0, 9'd5);

    // VPN-only flush: set 1 holds the match, set 3 reconstructs to 0x12347.
    clear_mem();
    mem_valid[1][2] = 1'b1; mem_tag[1][2] = 16'h1234; mem_asid[1][2] = 9'd77; mem_g[1][2] = 1'b1;
    mem_valid[3][0] = 1'b1; mem_tag[3][0] = 16'h1234;
    mem_valid[1][0] = 1'b1; mem_tag[1][0] = 16'h1235;
    run_flush("vpn", 1'b1, 1'b0, 20'h12345, 9'h0);

    // VPN+ASID flush: the global way survives.
    clear_mem();
    mem_valid[1][0] = 1'b1; mem_tag[1][0] = 16'h1234; mem_asid[1][0] = 9'd5; mem_g[1][0] = 1'b0;
    mem_valid[1][1] = 1'b1; mem_tag[1][1] = 16'h1234; mem_asid[1][1] = 9'd5; mem_g[1][1] = 1'b1;
    run_flush("vpn_asid", 1'b1, 1'b1, 20'h12345, 9'd5);

    // Randomized flushes against randomized contents.
    for (int it = 0; it < 8; it++) begin
      rvpn  = 20'($urandom);
      rasid = 9'($urandom_range(0, 3));
      rand_mem(3, rvpn[19:4], int'(rvpn[3:0] ^ rvpn[7:4]));
      run_flush("rand", 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), rvpn, rasid);
    end

    // Reset during the CHECK of set 7.
    for (int s = 0; s < NSET; s++) for (int w = 0; w < NW; w++) mem_valid[s][w] = 1'b1;
    @(negedge CLK);
    sfence_valid = 1'b1; sfence_VPN_specific = 1'b0; sfence_ASID_specific = 1'b0;
    @(posedge CLK);
    #1 sfence_valid = 1'b0;
    repeat (16) @(negedge CLK);
    chk("mid_check_idx", 32'(array_inv_index), 32'd7);
    chk("mid_check_valid", 32'(array_inv_valid), 32'd1);
    #1 nRST = 1'b0;
    #1;
    chk("mid_rst_inv", {28'(array_inv_valid), array_inv_way_mask}, 32'd0);
    chk("mid_rst_busy_done", {30'(busy), done, array_read_valid}, 32'd0);
    chk("mid_rst_ready", 32'(sfence_ready), 32'd1);
    cnt = 0;
    for (int n = 0; n < 4; n++) begin
      @(negedge CLK);
      if (done || busy) cnt++;
    end
    chk("mid_rst_no_done", 32'(cnt), 32'd0);
    nRST = 1'b1;
    rand_mem(3, 16'h0abc, 0);
    run_flush("after_rst", 1'b0, 1'b1, 20'h0, 9'd2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
